// File: rtl/c16_kbd_pkg.sv
// Shared types and constants for the C16 PS/2 keyboard event path.
// Event format: [10] toggle, [9] pressed, [8:0] scancode.
package c16_kbd_pkg;

  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;

  localparam int TOGGLE  = 10;
  localparam int PRESSED = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SH_DN,
    S_KEY_DN,
    S_HOLD,
    S_KEY_UP,
    S_SH_UP,
    S_GAP
  } inj_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c16_key_fifo.sv
// Injected-key queue: synchronous FIFO with flush.
// Flush has priority over write and read in the same cycle.
module c16_key_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rp_q];
  assign do_wr   = wr_en & ~full & ~flush;
  assign do_rd   = rd_en & ~empty & ~flush;

  always_comb begin
    wp_d  = wp_q + AW'(do_wr);
    rp_d  = rp_q + AW'(do_rd);
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: rtl/c16_key_injector.sv
// Merges live PS/2 events with timed injected key sequences
// so the 50 Hz KERNAL scan sees every injected key.
module c16_key_injector
  import c16_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 1200000,
  parameter int MIN_SPACING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key_in,
  output logic [10:0] ps2_key_out,
  input  logic [9:0]  inj_data,
  input  logic        inj_valid,
  output logic        inj_ready,
  input  logic        inj_abort,
  output logic        busy
);

  localparam int CW  = $clog2(max2(max2(HOLD_CYCLES, GAP_CYCLES), 2));
  localparam int SPW = $clog2(max2(MIN_SPACING, 2));
  localparam int FAW = $clog2(FIFO_DEPTH);

  inj_state_e     state_q, state_d;
  logic [9:0]     cur_q, cur_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [10:0]    out_q, out_d;
  logic           live_q, live_d;
  logic           abt_q, abt_d;

  logic           fifo_wr, fifo_rd;
  logic           fifo_full, fifo_empty;
  logic [9:0]     fifo_head;
  logic [FAW:0]   fifo_count;

  logic           live_ev, go, emit, emit_prs;
  logic [8:0]     emit_sc;

  assign fifo_wr   = inj_valid & inj_ready & ~inj_abort;
  assign inj_ready = ~fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != S_IDLE);
  assign live_ev   = ps2_key_in[TOGGLE] ^ live_q;
  // Live traffic always owns the cycle it arrives in.
  assign go        = (sp_q == '0) & ~live_ev & ~inj_abort;
  assign ps2_key_out = out_q;

  c16_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .flush   (inj_abort),
    .wr_en   (fifo_wr),
    .wr_data (inj_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      sp_q    <= '0;
      out_q   <= '0;
      live_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      out_q   <= out_d;
      live_q  <= live_d;
      abt_q   <= abt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    abt_d   = abt_q;
    fifo_rd = 1'b0;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    unique case (state_q)
      S_IDLE: begin
        abt_d = 1'b0;
        if (!fifo_empty && !inj_abort) begin
          fifo_rd = 1'b1;
          cur_d   = fifo_head;
          state_d = fifo_head[9] ? S_SH_DN : S_KEY_DN;
        end
      end
      S_SH_DN: begin
        if (inj_abort)  state_d = S_IDLE;
        else if (emit)  state_d = S_KEY_DN;
      end
      S_KEY_DN: begin
        if (inj_abort) begin
          abt_d   = 1'b1;
          state_d = cur_q[9] ? S_SH_UP : S_IDLE;
        end else if (emit) begin
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inj_abort) begin
          abt_d   = 1'b1;
          state_d = S_KEY_UP;
        end else if (cnt_q == '0) begin
          state_d = S_KEY_UP;
        end
      end
      S_KEY_UP: begin
        if (inj_abort) begin
          abt_d = 1'b1;
        end else if (emit) begin
          if (cur_q[9]) begin
            state_d = S_SH_UP;
          end else if (abt_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end
      end
      S_SH_UP: begin
        if (inj_abort) begin
          abt_d = 1'b1;
        end else if (emit) begin
          if (abt_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (inj_abort || cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    emit     = 1'b0;
    emit_prs = 1'b0;
    emit_sc  = cur_q[8:0];
    unique case (state_q)
      S_SH_DN: begin
        emit     = go;
        emit_prs = 1'b1;
        emit_sc  = SC_LSHIFT;
      end
      S_KEY_DN: begin
        emit     = go;
        emit_prs = 1'b1;
      end
      S_KEY_UP: emit = go;
      S_SH_UP: begin
        emit    = go;
        emit_sc = SC_LSHIFT;
      end
      default: emit = 1'b0;
    endcase
  end

  always_comb begin
    live_d = ps2_key_in[TOGGLE];
    out_d  = out_q;
    sp_d   = (sp_q != '0) ? sp_q - SPW'(1) : '0;
    if (live_ev) begin
      out_d         = ps2_key_in;
      out_d[TOGGLE] = ~out_q[TOGGLE];
    end else if (emit) begin
      out_d[TOGGLE]  = ~out_q[TOGGLE];
      out_d[PRESSED] = emit_prs;
      out_d[8:0]     = emit_sc;
    end
    if (live_ev || emit) sp_d = SPW'(MIN_SPACING - 1);
  end

endmodule

// File: tb/tb_c16_key_injector.sv
// Bench for c16_key_injector: random keys against a queue model
// of the expected press/release event stream.
module tb_c16_key_injector;
  import c16_kbd_pkg::*;

  localparam int HOLD  = 20;
  localparam int GAP   = 20;
  localparam int SPC   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key_in = '0;
  logic [10:0] ps2_key_out;
  logic [9:0]  inj_data = '0;
  logic        inj_valid = 1'b0;
  logic        inj_ready;
  logic        inj_abort = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [9:0] ev_q[$];
  int         et_q[$];
  logic [9:0] exp_q[$];
  logic       last_tog = 1'b0;

  c16_key_injector #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .MIN_SPACING (SPC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_key_in  (ps2_key_in),
    .ps2_key_out (ps2_key_out),
    .inj_data    (inj_data),
    .inj_valid   (inj_valid),
    .inj_ready   (inj_ready),
    .inj_abort   (inj_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      last_tog <= 1'b0;
    end else if (ps2_key_out[10] != last_tog) begin
      last_tog <= ps2_key_out[10];
      ev_q.push_back(ps2_key_out[9:0]);
      et_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    ev_q.delete();
    et_q.delete();
    exp_q.delete();
  endtask

  // Model: a key is shift-wrapped press then release.
  task automatic add_key(input logic [9:0] k);
    if (k[9]) exp_q.push_back({1'b1, SC_LSHIFT});
    exp_q.push_back({1'b1, k[8:0]});
    exp_q.push_back({1'b0, k[8:0]});
    if (k[9]) exp_q.push_back({1'b0, SC_LSHIFT});
  endtask

  function automatic logic [9:0] rnd_key(input logic sh);
    return {sh, 9'($urandom_range(0, 511))};
  endfunction

  function automatic int last_t();
    return (et_q.size() > 0) ? et_q[et_q.size()-1] : 0;
  endfunction

  function automatic int ev_dt(input int a, input int b);
    return (et_q.size() > b) ? et_q[b] - et_q[a] : -1;
  endfunction

  task automatic push(input logic [9:0] d);
    int w = 0;
    while (!inj_ready && w < 5000) begin
      tick();
      w++;
    end
    check("push_ready", inj_ready, 1);
    inj_data  = d;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    int w = 0;
    while (busy && w < 20000) begin
      tick();
      w++;
    end
    check("idle_timeout", busy, 0);
    t = cyc;
  endtask

  task automatic wait_events(input int n);
    int w = 0;
    while (ev_q.size() < n && w < 1000) begin
      tick();
      w++;
    end
    check("ev_wait", ev_q.size() >= n, 1);
  endtask

  task automatic compare_log(input string tag);
    int n;
    int mind;
    check($sformatf("%s_count", tag), ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
    mind = 1000;
    for (int i = 1; i < et_q.size(); i++)
      if (et_q[i] - et_q[i-1] < mind) mind = et_q[i] - et_q[i-1];
    check($sformatf("%s_spacing", tag), mind >= SPC, 1);
  endtask

  initial begin
    int t;
    int d;
    logic [9:0] k;
    logic [9:0] lv;
    logic [9:0] plain_k[3];
    logic [9:0] shift_k[3];

    repeat (3) tick();
    check("rst_out", ps2_key_out, 0);
    check("rst_ready", inj_ready, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("post_rst_out", ps2_key_out, 0);
    check("post_rst_busy", busy, 0);

    // live pass-through: press then release
    for (int i = 0; i < 2; i++) begin
      clear_log();
      lv = {(i == 0), 9'h01C};
      exp_q.push_back(lv);
      t = cyc;
      ps2_key_in = {~ps2_key_in[10], lv};
      tick();
      tick();
      compare_log("live");
      check("live_lat", (et_q.size() > 0) ? et_q[0] - t : -1, 1);
      check("live_out", ps2_key_out, {ps2_key_in[10], lv});
      check("live_busy", busy, 0);
      repeat (SPC) tick();
    end

    // plain injected keys
    plain_k[0] = 10'h02D;
    plain_k[1] = rnd_key(1'b0);
    plain_k[2] = rnd_key(1'b0);
    for (int i = 0; i < 3; i++) begin
      clear_log();
      add_key(plain_k[i]);
      push(plain_k[i]);
      wait_idle(t);
      compare_log("plain");
      d = ev_dt(0, 1);
      check("plain_hold", d >= HOLD && d <= HOLD + 3, 1);
      check("plain_gap", t - last_t() >= GAP, 1);
    end

    // shifted injected keys
    shift_k[0] = 10'h21E;
    shift_k[1] = rnd_key(1'b1);
    shift_k[2] = rnd_key(1'b1);
    for (int i = 0; i < 3; i++) begin
      clear_log();
      add_key(shift_k[i]);
      push(shift_k[i]);
      wait_idle(t);
      compare_log("shift");
      d = ev_dt(1, 2);
      check("shift_hold", d >= HOLD && d <= HOLD + 3, 1);
      check("shift_gap", t - last_t() >= GAP, 1);
    end

    // live toggle lands on the cycle the first injected press is due
    for (int i = 0; i < 2; i++) begin
      clear_log();
      k  = rnd_key(i[0]);
      lv = {1'($urandom_range(0, 1)), 9'($urandom_range(0, 511))};
      exp_q.push_back(lv);
      add_key(k);
      push(k);
      tick();
      ps2_key_in = {~ps2_key_in[10], lv};
      wait_idle(t);
      compare_log("contend");
      d = ev_dt(0, 1);
      check("contend_delay", d >= SPC && d <= SPC + 1, 1);
    end

    // fill the queue behind one key in flight
    clear_log();
    for (int i = 0; i < DEPTH + 1; i++) begin
      k = rnd_key(1'($urandom_range(0, 1)));
      add_key(k);
      push(k);
    end
    check("full_ready", inj_ready, 0);
    check("full_busy", busy, 1);
    wait_idle(t);
    compare_log("fifo");
    check("fifo_ready_after", inj_ready, 1);

    // abort during HOLD of a shifted key with more keys queued
    clear_log();
    k = rnd_key(1'b1);
    add_key(k);
    push(k);
    push(rnd_key(1'b0));
    push(rnd_key(1'b1));
    wait_events(2);
    repeat (5) tick();
    inj_abort = 1'b1;
    tick();
    inj_abort = 1'b0;
    check("abort_ready", inj_ready, 1);
    wait_idle(t);
    check("abort_nogap", t - last_t() <= 2, 1);
    repeat (60) tick();
    compare_log("abort");
    check("abort_flushed", busy, 0);

    // abort in the same cycle as a write discards the write
    clear_log();
    inj_data  = rnd_key(1'b0);
    inj_valid = 1'b1;
    inj_abort = 1'b1;
    tick();
    inj_valid = 1'b0;
    inj_abort = 1'b0;
    check("abort_wr_busy", busy, 0);
    repeat (40) tick();
    compare_log("abort_wr");

    // reset mid-sequence emits no release
    clear_log();
    k = rnd_key(1'b1);
    exp_q.push_back({1'b1, SC_LSHIFT});
    exp_q.push_back({1'b1, k[8:0]});
    push(k);
    wait_events(2);
    repeat (3) tick();
    reset = 1'b1;
    ps2_key_in = '0;
    tick();
    check("midrst_out", ps2_key_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", inj_ready, 1);
    reset = 1'b0;
    repeat (60) tick();
    compare_log("midrst");
    check("midrst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c16_key_injector.md
Name: c16_key_injector

Overview:
- Scheduler that shares the single 11-bit PS/2 event bus feeding the C16 keyboard matrix between two requesters: the live PS/2 keyboard and a programmatic key injector (OSD paste / autostart "RUN" typing).
- Live events pass through with priority. Queued injected keys become timed press/hold/release sequences, with optional shift wrapping, spaced so the KERNAL keyboard scan (50 Hz) sees every key.
- Sits between hps_io ps2_key and the keyboard-matrix ps2_key input.

Parameters:
- FIFO_DEPTH, 16, injected-key queue entries (power of two, 2..256).
- HOLD_CYCLES, 1200000, clk cycles a key (and its shift) stays pressed (~42 ms at 28.288 MHz, i.e. at least two scans).
- GAP_CYCLES, 1200000, clk cycles all injected keys stay released before the next queued key.
- MIN_SPACING, 4, minimum clk cycles between any two toggles of ps2_key_out[10].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key_in  in  11  live keyboard event: [10] toggle, [9] pressed, [8:0] scancode ([8] = E0 extended).
- ps2_key_out  out  11  merged event stream to the keyboard matrix, same format.
- inj_data  in  10  [9] shift required, [8:0] scancode.
- inj_valid  in  1  inj_data present.
- inj_ready  out  1  queue can accept; a transfer happens when inj_valid & inj_ready.
- inj_abort  in  1  single-cycle pulse: flush queue and release any injected key.
- busy  out  1  queue non-empty or sequencer not IDLE.

Behaviour:
- Reset: ps2_key_out = 0, inj_ready = 1, busy = 0, FIFO empty, FSM IDLE, counters 0. The live-toggle tracking register is loaded with 0 on reset.
- Live path: edge detect ps2_key_in[10] against a registered copy. On change, the next cycle flips ps2_key_out[10] and copies [9:0] from ps2_key_in. Latency is exactly 1 clk.
- Live wins any same-cycle contention. A pending injected event waits until the spacing counter allows it.
- Spacing counter: reloads MIN_SPACING-1 on every output toggle and counts down. Injected events are emitted only when it is 0.
- Live events are never delayed. The host guarantees live events are separated by at least MIN_SPACING.
- FIFO:
  - inj_ready = !full.
  - A write while full cannot occur; inj_valid with ready low is held by the requester.
  - Simultaneous write and pop are both performed, and the count is unchanged.
- FSM states: IDLE, SH_DN, KEY_DN, HOLD, KEY_UP, SH_UP, GAP.
  - IDLE: if the FIFO is non-empty, pop the head into a current-key register. Go to SH_DN if [9] is set, else KEY_DN.
  - SH_DN: emit {toggle, 1, 9'h012} when spacing allows, then go to KEY_DN.
  - KEY_DN: emit {toggle, 1, scancode}, load the hold counter with HOLD_CYCLES-1, then go to HOLD.
  - HOLD: count to 0, then go to KEY_UP.
  - KEY_UP: emit {toggle, 0, scancode}. Go to SH_UP if shift was used, else load GAP_CYCLES-1 and go to GAP.
  - SH_UP: emit {toggle, 0, 9'h012}, load the gap counter, go to GAP.
  - GAP: count to 0, then go to IDLE.
  - Each emit state waits in place until spacing is 0 and no live event is being forwarded that cycle.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES)). Counters saturate at 0 and never wrap.
- inj_abort:
  - Clears the FIFO immediately.
  - From IDLE or GAP: go to IDLE.
  - From SH_DN: go to IDLE (nothing pressed).
  - From KEY_DN: go to SH_UP if shift was pressed, else IDLE.
  - From HOLD or KEY_UP: go to KEY_UP. Releases still respect spacing.
  - From SH_UP: stays in SH_UP.
  - After abort, the release path goes to IDLE instead of GAP.
  - Abort in the same cycle as a FIFO write: abort wins and the write is discarded.
- busy: asserted while the FIFO is non-empty or the FSM is not IDLE. It deasserts the cycle the FSM returns to IDLE with the FIFO empty.
- Reset mid-sequence: all state is cleared and no release is emitted. The keyboard matrix is reset by the same reset.

Decomposition:
- Package c16_kbd_pkg:
  - scancode constants SC_LSHIFT = 9'h012 and SC_RSHIFT = 9'h059;
  - state enum of the 7 states above;
  - ps2 event field indices (TOGGLE = 10, PRESSED = 9).
- Sub-module c16_key_fifo: synchronous FIFO, FIFO_DEPTH x 10 bits, with full/empty/count, an asynchronous reset, and a synchronous flush input driven by inj_abort.

Test Plan:
- Live pass-through: toggle ps2_key_in with {1, 9'h01C} -> ps2_key_out = {~prev, 1, 9'h01C} exactly 1 clk later. No injected activity.
- Plain inject (HOLD = GAP = 20, MIN_SPACING = 4): write 10'h02D -> press 0x02D, release 0x02D 20 clk later, busy low after GAP, 2 toggles total.
- Shifted inject: write 10'h21E -> ordered events 0x012 down, 0x01E down, 0x01E up, 0x012 up. Consecutive toggles are at least 4 clk apart.
- Contention: a live toggle lands in the same cycle an injected press is due -> live forwarded first, injected press follows at least 4 clk later. Both are visible and in order.
- Queue full: write 16 entries with no pop -> inj_ready = 0 on the 16th accept. All 16 keys are later emitted in FIFO order.
- Abort in HOLD on a shifted key: inj_abort -> releases 0x0xx then 0x012 emitted, FIFO count 0, busy falls with no GAP wait, pending queued keys never appear.
